// File: rtl/vip_csc_frame_ctrl.sv
// rtl/vip_csc_frame_ctrl.sv - frame sequencer gating sync strobes into the YCbCr-to-RGB CSC
module vip_csc_frame_ctrl #(
    parameter int LATENCY = 3,
    parameter int CNT_W   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             per_frame_vsync,
    input  logic             per_frame_href,
    input  logic             per_frame_clken,
    input  logic             cfg_en,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_h_active,
    input  logic [CNT_W-1:0] cfg_v_active,
    input  logic             err_clr,
    output logic             csc_frame_vsync,
    output logic             csc_frame_href,
    output logic             csc_frame_clken,
    output logic [1:0]       csc_mode,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      frame_cnt,
    output logic             size_err
);
    localparam int DW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ARMED, RUN, DRAIN} state_t;

    state_t           state;
    logic             vsync_d;
    logic             href_d;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] line_cnt;
    logic [CNT_W-1:0] line_nxt;
    logic [CNT_W-1:0] h_active;
    logic [CNT_W-1:0] v_active;
    logic [DW-1:0]    drain_cnt;
    logic             vs_rise;
    logic             vs_fall;
    logic             line_end;
    logic             gate;
    logic             err_set;

    // A line also ends when vsync drops while href_d is still high, so the
    // last line is counted before the frame-height check uses line_nxt.
    always_comb begin
        vs_rise  = per_frame_vsync & ~vsync_d;
        vs_fall  = ~per_frame_vsync & vsync_d;
        line_end = href_d & (~per_frame_href | vs_fall);
        gate     = (state == ARMED && vs_rise) || (state == RUN);
        line_nxt = line_cnt;
        if (line_end && line_cnt != '1) begin
            line_nxt = line_cnt + CNT_W'(1);
        end
        err_set = (state == RUN) &&
                  ((line_end && pix_cnt != h_active) || (vs_fall && line_nxt != v_active));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            vsync_d         <= 1'b0;
            href_d          <= 1'b0;
            pix_cnt         <= '0;
            line_cnt        <= '0;
            h_active        <= '0;
            v_active        <= '0;
            drain_cnt       <= '0;
            csc_frame_vsync <= 1'b0;
            csc_frame_href  <= 1'b0;
            csc_frame_clken <= 1'b0;
            csc_mode        <= 2'd0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            frame_cnt       <= 16'd0;
            size_err        <= 1'b0;
        end else begin
            vsync_d         <= per_frame_vsync;
            href_d          <= per_frame_href;
            csc_frame_vsync <= per_frame_vsync & gate;
            csc_frame_href  <= per_frame_href & gate;
            csc_frame_clken <= per_frame_clken & gate;
            frame_done      <= 1'b0;

            if (err_set) begin
                size_err <= 1'b1;
            end else if (err_clr) begin
                size_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cfg_en) begin
                        state <= ARMED;
                        busy  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (!cfg_en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (vs_rise) begin
                        csc_mode <= cfg_mode;
                        h_active <= cfg_h_active;
                        v_active <= cfg_v_active;
                        pix_cnt  <= '0;
                        line_cnt <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (line_end) begin
                        pix_cnt <= '0;
                    end else if (per_frame_href && per_frame_clken && pix_cnt != '1) begin
                        pix_cnt <= pix_cnt + CNT_W'(1);
                    end
                    line_cnt <= line_nxt;
                    if (vs_fall) begin
                        state     <= DRAIN;
                        drain_cnt <= DW'(LATENCY);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DW'(1)) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        state      <= cfg_en ? ARMED : IDLE;
                        busy       <= cfg_en;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
